lane_trigger_aggregator: RTL and testbench
==========================================

Name: lane_trigger_aggregator

Overview:
- Parametrised successor to the fixed 20-row interrupt-OR/group-reset glue in the CompAIR FEE top level.
- Synchronises per-lane active-low interrupts and masks them per lane.
- Generates a shaped trigger in OR or multiplicity mode, with hold-off, a captured hit pattern behind a valid/ready handshake, saturating statistics, and grouped chip reset outputs.
- Sits between the lane pins and the astep24 core / FEE trigger output.

Parameters:
- NLANES, 20, number of lanes (rows).
- GROUP_SIZE, 4, lanes sharing one reset pin; NGROUPS = ceil(NLANES/GROUP_SIZE).
- SYNC_STAGES, 2, synchroniser depth on lane_interruptn (min 2).
- CNT_W, 16, width of the statistics counters.
- TW_W, 8, width of trigger-width and hold-off configuration.

Ports:
- sysclk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- lane_interruptn  in  NLANES  asynchronous active-low hit interrupts from the chips.
- lane_resn  in  NLANES  per-lane active-low reset requests from the core.
- cfg_lane_mask  in  NLANES  1 = lane ignored for triggering.
- cfg_mode  in  1  0 = OR of new hits; 1 = multiplicity.
- cfg_mult_thr  in  $clog2(NLANES+1)  multiplicity threshold.
- cfg_trig_width  in  TW_W  trig_out high time in cycles.
- cfg_holdoff  in  TW_W  dead cycles after trig_out.
- cfg_reset_any  in  1  1 = group reset when any member lane requests it; 0 = only when all members request it.
- cnt_clear  in  1  synchronous clear of the counters and the overflow flag.
- trig_out  out  1  shaped trigger.
- fee_hit  out  1  active-low one-cycle pulse on the trig_out falling edge.
- trig_valid  out  1  pattern available.
- trig_ready  in  1  consumer accepts the pattern.
- trig_pattern  out  NLANES  unmasked active lanes at trigger time.
- group_resn  out  NGROUPS  registered group reset pins.
- trig_count  out  CNT_W  accepted triggers, saturating.
- drop_count  out  CNT_W  hits lost in ACTIVE/HOLDOFF, saturating.
- pattern_ovf  out  1  sticky; a pattern was lost because trig_valid was still high.

Behaviour:
- Reset values (rstn low, asynchronous):
  - trig_out = 0, fee_hit = 1, trig_valid = 0, trig_pattern = 0.
  - group_resn = all 0 (chips held in reset).
  - counters = 0, pattern_ovf = 0, state = IDLE, synchronisers = all 1.
- Input conditioning:
  - lane_act[i] = !sync(lane_interruptn[i]) & !cfg_lane_mask[i].
  - new_hit[i] = lane_act[i] & !lane_act_d[i].
- Trigger condition:
  - Mode 0: |new_hit.
  - Mode 1: popcount(lane_act) >= max(cfg_mult_thr, 1), and the same comparison was false the previous cycle (rising condition).
  - A threshold greater than NLANES never fires.
- State machine (registered):
  - IDLE → ACTIVE on the trigger condition. trig_out = 1, trig_count increments, pattern captured, all on the same edge.
  - Latency: an interrupt low before edge k gives trig_out = 1 after edge k+SYNC_STAGES+1.
  - ACTIVE stays for max(cfg_trig_width, 1) cycles, then goes to HOLDOFF (or straight to IDLE if cfg_holdoff = 0). fee_hit = 0 for the single cycle after trig_out falls.
  - HOLDOFF counts cfg_holdoff cycles, then returns to IDLE.
  - Any trigger condition in ACTIVE or HOLDOFF increments drop_count by 1 per cycle it is true.
  - Configuration is sampled when a counter loads; changes mid-pulse do not affect the current pulse.
- Pattern handshake:
  - On trigger with trig_valid = 0: load the pattern and set trig_valid.
  - On trigger with trig_valid = 1 and no accept in the same cycle: keep the old pattern and set pattern_ovf; the trigger is still issued.
  - Accept and new trigger in the same cycle: load the new pattern, trig_valid stays 1.
  - Accept only: trig_valid = 0.
  - trig_pattern is stable while trig_valid = 1.
- Counters:
  - Saturate at all-ones.
  - cnt_clear wins over a simultaneous increment (result 0); it does not affect state or the pattern.
- Group reset:
  - group_resn[g] is registered. cfg_reset_any = 1: AND of the member lane_resn; 0: OR.
  - A partial last group uses only the lanes that exist.
  - No synchroniser (lane_resn is already in the sysclk domain).
- Reset mid-pulse: outputs return to reset values immediately; no fee_hit pulse is generated.

Decomposition:
- Package compair_trig_pkg:
  - trig_state_e {IDLE, ACTIVE, HOLDOFF};
  - trig_mode_e {MODE_OR, MODE_MULT};
  - ngroups() function.
- Sub-module lane_sync_edge: vector synchroniser, mask, and rising-activity detect. Outputs lane_act and new_hit.

Test Plan:
- Mode 0, width 3, holdoff 4: drop lane 5 low → trig_out high 3 cycles at latency SYNC_STAGES+1; fee_hit low 1 cycle; trig_pattern = 1<<5; trig_count = 1.
- Mode 0, holdoff 4, lane 2 falls during HOLDOFF → no trigger, drop_count = 1; same lane falling after IDLE → trigger.
- Mode 1, thr 3: lanes 0,1 low → nothing; lane 7 low → one trigger, pattern 0x83; lanes stay low → no retrigger.
- trig_ready = 0, two triggers → first pattern held, pattern_ovf = 1; assert ready with a simultaneous trigger → new pattern, valid stays 1.
- cfg_reset_any 1/0 with lane_resn[1] = 0 only → group_resn[0] = 0 / 1; NLANES = 22 partial group checked.
- Drive trig_count to 0xFFFF → stays 0xFFFF; cnt_clear plus a trigger in the same cycle → 0; rstn low during ACTIVE → trig_out = 0 immediately, fee_hit stays 1.

Source files
------------

// File: rtl/compair_trig_pkg.sv
// Shared types and helpers for the lane trigger aggregator.
// Imported by the lane conditioning and trigger shaping logic.
package compair_trig_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        HOLDOFF = 2'd2
    } trig_state_e;

    typedef enum logic {
        MODE_OR   = 1'b0,
        MODE_MULT = 1'b1
    } trig_mode_e;

    function automatic int ngroups(input int nlanes, input int group_size);
        return (nlanes + group_size - 1) / group_size;
    endfunction

endpackage

// File: rtl/lane_sync_edge.sv
// Per-lane interrupt synchroniser, lane mask and rising-activity detect.
// lane_act is registered so a hit reaches the trigger one cycle after sync.
module lane_sync_edge #(
    parameter int NLANES      = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sysclk,
    input  logic              rstn,
    input  logic [NLANES-1:0] lane_interruptn,
    input  logic [NLANES-1:0] cfg_lane_mask,
    output logic [NLANES-1:0] lane_act,
    output logic [NLANES-1:0] new_hit
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [NLANES-1:0] sync_q [STAGES];
    logic [NLANES-1:0] act_d;

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= '1;
            end
            lane_act <= '0;
            act_d    <= '0;
        end else begin
            sync_q[0] <= lane_interruptn;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            lane_act <= ~sync_q[STAGES-1] & ~cfg_lane_mask;
            act_d    <= lane_act;
        end
    end

    assign new_hit = lane_act & ~act_d;

endmodule

// File: rtl/lane_trigger_aggregator.sv
// Lane interrupt aggregation: shaped trigger, captured hit pattern,
// saturating statistics and grouped chip reset pins.
module lane_trigger_aggregator
    import compair_trig_pkg::*;
#(
    parameter int NLANES      = 20,
    parameter int GROUP_SIZE  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TW_W        = 8
) (
    input  logic                                  sysclk,
    input  logic                                  rstn,
    input  logic [NLANES-1:0]                     lane_interruptn,
    input  logic [NLANES-1:0]                     lane_resn,
    input  logic [NLANES-1:0]                     cfg_lane_mask,
    input  logic                                  cfg_mode,
    input  logic [$clog2(NLANES+1)-1:0]           cfg_mult_thr,
    input  logic [TW_W-1:0]                       cfg_trig_width,
    input  logic [TW_W-1:0]                       cfg_holdoff,
    input  logic                                  cfg_reset_any,
    input  logic                                  cnt_clear,
    output logic                                  trig_out,
    output logic                                  fee_hit,
    output logic                                  trig_valid,
    input  logic                                  trig_ready,
    output logic [NLANES-1:0]                     trig_pattern,
    output logic [ngroups(NLANES, GROUP_SIZE)-1:0] group_resn,
    output logic [CNT_W-1:0]                      trig_count,
    output logic [CNT_W-1:0]                      drop_count,
    output logic                                  pattern_ovf
);

    localparam int TH_W    = $clog2(NLANES + 1);
    localparam int NGROUPS = ngroups(NLANES, GROUP_SIZE);
    localparam int PAD_W   = NGROUPS * GROUP_SIZE;

    logic [NLANES-1:0] lane_act;
    logic [NLANES-1:0] new_hit;
    logic [TH_W-1:0]   act_cnt;
    logic [TH_W-1:0]   thr_eff;
    logic              mult_hit;
    logic              mult_d;
    logic              trig_cond;
    logic              fire;
    logic              pulse_end;
    trig_state_e       state;
    logic [TW_W-1:0]   cnt;
    logic [PAD_W-1:0]  resn_and;
    logic [PAD_W-1:0]  resn_or;

    lane_sync_edge #(
        .NLANES      (NLANES),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .sysclk          (sysclk),
        .rstn            (rstn),
        .lane_interruptn (lane_interruptn),
        .cfg_lane_mask   (cfg_lane_mask),
        .lane_act        (lane_act),
        .new_hit         (new_hit)
    );

    always_comb begin
        act_cnt   = TH_W'($countones(lane_act));
        thr_eff   = (cfg_mult_thr == '0) ? TH_W'(1) : cfg_mult_thr;
        mult_hit  = (act_cnt >= thr_eff);
        if (trig_mode_e'(cfg_mode) == MODE_MULT) begin
            trig_cond = mult_hit & ~mult_d;
        end else begin
            trig_cond = |new_hit;
        end
        fire      = trig_cond & (state == IDLE);
        pulse_end = (state == ACTIVE) & (cnt == '0);
    end

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            cnt     <= '0;
            fee_hit <= 1'b1;
            mult_d  <= 1'b0;
        end else begin
            mult_d  <= mult_hit;
            fee_hit <= ~pulse_end;
            unique case (state)
                IDLE: begin
                    if (fire) begin
                        state <= ACTIVE;
                        cnt   <= (cfg_trig_width == '0) ? '0
                                 : cfg_trig_width - TW_W'(1);
                    end
                end
                ACTIVE: begin
                    if (cnt != '0) begin
                        cnt <= cnt - TW_W'(1);
                    end else if (cfg_holdoff == '0) begin
                        state <= IDLE;
                    end else begin
                        state <= HOLDOFF;
                        cnt   <= cfg_holdoff - TW_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt != '0) begin
                        cnt <= cnt - TW_W'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign trig_out = (state == ACTIVE);

    // A busy holding register keeps its pattern; the loss is only flagged.
    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            trig_valid   <= 1'b0;
            trig_pattern <= '0;
            pattern_ovf  <= 1'b0;
        end else begin
            if (fire && (!trig_valid || trig_ready)) begin
                trig_valid   <= 1'b1;
                trig_pattern <= lane_act;
            end else if (trig_valid && trig_ready) begin
                trig_valid <= 1'b0;
            end
            if (cnt_clear) begin
                pattern_ovf <= 1'b0;
            end else if (fire && trig_valid && !trig_ready) begin
                pattern_ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            trig_count <= '0;
            drop_count <= '0;
        end else begin
            if (cnt_clear) begin
                trig_count <= '0;
            end else if (fire && (trig_count != '1)) begin
                trig_count <= trig_count + CNT_W'(1);
            end
            if (cnt_clear) begin
                drop_count <= '0;
            end else if (trig_cond && (state != IDLE) && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    // Missing lanes of a partial last group are neutral for AND and OR.
    always_comb begin
        resn_and               = '1;
        resn_or                = '0;
        resn_and[NLANES-1:0]   = lane_resn;
        resn_or[NLANES-1:0]    = lane_resn;
    end

    always_ff @(posedge sysclk or negedge rstn) begin
        if (!rstn) begin
            group_resn <= '0;
        end else begin
            for (int g = 0; g < NGROUPS; g++) begin
                group_resn[g] <= cfg_reset_any
                    ? &resn_and[g*GROUP_SIZE +: GROUP_SIZE]
                    : |resn_or[g*GROUP_SIZE +: GROUP_SIZE];
            end
        end
    end

endmodule

// File: tb/tb_lane_trigger_aggregator.sv
// Randomised and directed bench for lane_trigger_aggregator with a
// cycle-numbered reference model and a pattern scoreboard.
module tb_lane_trigger_aggregator;

    localparam int NL   = 22;
    localparam int GS   = 4;
    localparam int SS   = 2;
    localparam int CW   = 8;
    localparam int TW   = 8;
    localparam int NG   = (NL + GS - 1) / GS;
    localparam int THW  = $clog2(NL + 1);
    localparam int CMAX = (1 << CW) - 1;

    logic           sysclk = 1'b0;
    logic           rstn = 1'b0;
    logic [NL-1:0]  lane_interruptn = '1;
    logic [NL-1:0]  lane_resn = '1;
    logic [NL-1:0]  cfg_lane_mask = '0;
    logic           cfg_mode = 1'b0;
    logic [THW-1:0] cfg_mult_thr = '0;
    logic [TW-1:0]  cfg_trig_width = 8'd1;
    logic [TW-1:0]  cfg_holdoff = 8'd0;
    logic           cfg_reset_any = 1'b1;
    logic           cnt_clear = 1'b0;
    logic           trig_ready = 1'b1;
    logic           trig_out;
    logic           fee_hit;
    logic           trig_valid;
    logic [NL-1:0]  trig_pattern;
    logic [NG-1:0]  group_resn;
    logic [CW-1:0]  trig_count;
    logic [CW-1:0]  drop_count;
    logic           pattern_ovf;

    int checks = 0;
    int errors = 0;

    always #5 sysclk = ~sysclk;

    lane_trigger_aggregator #(
        .NLANES(NL), .GROUP_SIZE(GS), .SYNC_STAGES(SS), .CNT_W(CW), .TW_W(TW)
    ) dut (
        .sysclk(sysclk), .rstn(rstn),
        .lane_interruptn(lane_interruptn), .lane_resn(lane_resn),
        .cfg_lane_mask(cfg_lane_mask), .cfg_mode(cfg_mode),
        .cfg_mult_thr(cfg_mult_thr), .cfg_trig_width(cfg_trig_width),
        .cfg_holdoff(cfg_holdoff), .cfg_reset_any(cfg_reset_any),
        .cnt_clear(cnt_clear), .trig_out(trig_out), .fee_hit(fee_hit),
        .trig_valid(trig_valid), .trig_ready(trig_ready),
        .trig_pattern(trig_pattern), .group_resn(group_resn),
        .trig_count(trig_count), .drop_count(drop_count),
        .pattern_ovf(pattern_ovf)
    );

    function automatic void chk(input string nm, input logic [63:0] a,
                                input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, a, e, $time);
        end
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Reference model: edge p fires when the rule holds and p is past
    // the previous pulse's width plus hold-off window.
    int            p, fire_p, fire_w, end_edge, mtrig, mdrop;
    bit            mprev, mval, movf, exp_trig, exp_fee;
    logic [NL-1:0] act_cur, act_prv;
    logic [NL-1:0] hist [SS];
    logic [NG-1:0] mgrp;
    logic [NL-1:0] exp_q [$];

    always @(posedge sysclk or negedge rstn) begin : model
        logic [NL-1:0] nh;
        int pc, thr;
        bit mc, cond, a, o;
        if (!rstn) begin
            p = 0; fire_p = -100; fire_w = 0; end_edge = -1;
            mtrig = 0; mdrop = 0; mprev = 0; mval = 0; movf = 0;
            act_cur = '0; act_prv = '0; mgrp = '0;
            exp_trig = 0; exp_fee = 1;
            for (int k = 0; k < SS; k++) hist[k] = '1;
        end else begin
            p++;
            nh   = act_cur & ~act_prv;
            pc   = $countones(act_cur);
            thr  = (cfg_mult_thr == 0) ? 1 : int'(cfg_mult_thr);
            mc   = (pc >= thr);
            cond = cfg_mode ? (mc && !mprev) : (nh != 0);
            mprev = mc;
            if (cond && p > end_edge) begin
                fire_p   = p;
                fire_w   = (cfg_trig_width == 0) ? 1 : int'(cfg_trig_width);
                end_edge = p + fire_w + int'(cfg_holdoff);
                mtrig    = sat(mtrig);
                if (!mval || trig_ready) begin
                    exp_q.push_back(act_cur);
                    mval = 1;
                end else begin
                    movf = 1;
                end
            end else begin
                if (cond) mdrop = sat(mdrop);
                if (mval && trig_ready) mval = 0;
            end
            if (cnt_clear) begin
                mtrig = 0; mdrop = 0; movf = 0;
            end
            for (int g = 0; g < NG; g++) begin
                a = 1; o = 0;
                for (int l = 0; l < NL; l++) begin
                    if (l / GS == g) begin
                        a = a & lane_resn[l];
                        o = o | lane_resn[l];
                    end
                end
                mgrp[g] = cfg_reset_any ? a : o;
            end
            act_prv = act_cur;
            act_cur = ~hist[SS-1] & ~cfg_lane_mask;
            for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = lane_interruptn;
            exp_trig = (p >= fire_p) && (p < fire_p + fire_w);
            exp_fee  = (p != fire_p + fire_w);
        end
    end

    always @(negedge sysclk) begin : monitor
        if (rstn) begin
            chk("trig_out", trig_out, exp_trig);
            chk("fee_hit", fee_hit, exp_fee);
            chk("trig_valid", trig_valid, mval);
            chk("pattern_ovf", pattern_ovf, movf);
            chk("trig_count", trig_count, mtrig);
            chk("drop_count", drop_count, mdrop);
            chk("group_resn", group_resn, mgrp);
            if (trig_valid && trig_ready) begin
                if (exp_q.size() == 0) begin
                    chk("pattern_unexpected", 1, 0);
                end else begin
                    chk("trig_pattern", trig_pattern, exp_q.pop_front());
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge sysclk);
            #2;
        end
    endtask

    task automatic quiet(input int n);
        lane_interruptn = '1;
        step(n);
    endtask

    task automatic setcfg(input bit m, input int thr, input int w, input int h);
        cfg_mode       = m;
        cfg_mult_thr   = THW'(thr);
        cfg_trig_width = TW'(w);
        cfg_holdoff    = TW'(h);
    endtask

    initial begin
        bit seen;
        step(2);
        chk("rst_trig_out", trig_out, 0);
        chk("rst_fee_hit", fee_hit, 1);
        chk("rst_valid", trig_valid, 0);
        chk("rst_pattern", trig_pattern, 0);
        chk("rst_group", group_resn, 0);
        chk("rst_counts", {trig_count, drop_count, 7'd0, pattern_ovf}, 0);
        rstn = 1'b1;
        step(4);

        setcfg(0, 0, 3, 4);
        lane_interruptn[5] = 1'b0;
        step(3);
        chk("latency_pre", trig_out, 0);
        step(1);
        chk("latency", trig_out, 1);
        step(10);
        chk("lane5_pattern", trig_pattern, 22'h20);
        quiet(10);

        lane_interruptn[0] = 1'b0;
        step(5);
        lane_interruptn[2] = 1'b0;
        step(12);
        chk("holdoff_drop", drop_count, 1);
        lane_interruptn[2] = 1'b1;
        step(4);
        lane_interruptn[2] = 1'b0;
        step(12);
        quiet(10);

        setcfg(1, 3, 2, 1);
        lane_interruptn[0] = 1'b0;
        lane_interruptn[1] = 1'b0;
        step(8);
        lane_interruptn[7] = 1'b0;
        step(15);
        chk("mult_pattern", trig_pattern, 22'h83);
        quiet(10);

        setcfg(0, 0, 2, 0);
        trig_ready = 1'b0;
        lane_interruptn[9] = 1'b0;
        step(8);
        lane_interruptn[10] = 1'b0;
        step(8);
        chk("ovf_set", pattern_ovf, 1);
        chk("ovf_held", trig_pattern, 22'h200);
        lane_interruptn[11] = 1'b0;
        step(3);
        trig_ready = 1'b1;
        step(1);
        chk("accept_reload", trig_valid, 1);
        quiet(10);

        lane_resn = '1;
        lane_resn[1] = 1'b0;
        cfg_reset_any = 1'b1;
        step(2);
        chk("grp_any", group_resn[0], 0);
        cfg_reset_any = 1'b0;
        step(2);
        chk("grp_all", group_resn[0], 1);
        lane_resn = '1;
        lane_resn[21] = 1'b0;
        step(2);
        lane_resn[20] = 1'b0;
        step(2);
        chk("grp_partial", group_resn[NG-1], 0);
        lane_resn = '1;
        cfg_reset_any = 1'b1;
        step(2);

        setcfg(0, 0, 1, 0);
        for (int i = 0; i < 270; i++) begin
            lane_interruptn[4] = 1'b0;
            step(2);
            lane_interruptn[4] = 1'b1;
            step(2);
        end
        chk("trig_sat", trig_count, CMAX);
        lane_interruptn[4] = 1'b0;
        step(3);
        cnt_clear = 1'b1;
        step(1);
        cnt_clear = 1'b0;
        chk("clear_wins", trig_count, 0);
        quiet(10);

        setcfg(0, 0, 5, 2);
        lane_interruptn[3] = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            seen = trig_out;
        end
        if (!seen) chk("reset_wait_timeout", 0, 1);
        step(1);
        rstn = 1'b0;
        #1;
        chk("rst_mid_trig", trig_out, 0);
        chk("rst_mid_fee", fee_hit, 1);
        lane_interruptn = '1;
        step(3);
        rstn = 1'b1;
        step(8);

        for (int r = 0; r < 6; r++) begin
            setcfg(1'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 30 : $urandom_range(0, 5),
                   $urandom_range(0, 4), $urandom_range(0, 5));
            cfg_lane_mask = NL'($urandom) & NL'($urandom);
            cfg_reset_any = 1'($urandom_range(0, 1));
            for (int c = 0; c < 150; c++) begin
                for (int l = 0; l < NL; l++) begin
                    if ($urandom_range(0, 7) == 0) lane_interruptn[l] = ~lane_interruptn[l];
                end
                trig_ready = ($urandom_range(0, 9) < 7);
                lane_resn  = NL'($urandom) | NL'($urandom);
                cnt_clear  = ($urandom_range(0, 49) == 0);
                step(1);
            end
            cnt_clear  = 1'b0;
            trig_ready = 1'b1;
            quiet(20);
        end

        trig_ready = 1'b1;
        quiet(30);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
